// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execute stage with registered result and flags.
// Logic/arith ops finish in one cycle, shifts iterate one bit per cycle, and
// an optional shift-add multiply is built only when ALU_MUL_EN is defined.
// flags = {C, L, F, Z, N}; a separate carry register feeds ADDC/ADDCU chains.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for in_valid, in_ready=1
// S_SHIFT | iterating a shift, one bit per cycle
// S_MUL   | shift-add multiply, WIDTH iterations (ALU_MUL_EN only)
// S_DONE  | out/flags valid and held until out_ready
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [3:0]       exop,
  input  logic [WIDTH-1:0] Rdest,
  input  logic [WIDTH-1:0] Rsrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [4:0]       flags
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_MUL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif
  typedef enum logic [1:0] {K_ONE, K_SHIFT, K_MUL} kind_t;

  localparam logic [3:0] OP_R     = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [1:0] SH_LEFT  = 2'd0;
  localparam logic [1:0] SH_LRGT  = 2'd1;
  localparam logic [1:0] SH_ARGT  = 2'd2;
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  state_t           state;
  logic [WIDTH-1:0] out_q;
  logic [4:0]       flags_q;
  logic             carry_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] sh_reg;
  logic [SHW:0]     sh_cnt;
  logic [1:0]       sh_mode;
  logic [WIDTH-1:0] sh_next;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  logic [4:0]       flg_c;
  logic             cry_c;
  logic             use_cin;
  logic             ovf;
  logic             is_shift;
  kind_t            kind_c;
  logic [1:0]       mode_c;

`ifdef ALU_MUL_EN
  localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [2*WIDTH-1:0] mul_next;
`endif

  // Z/N from a result with C, L, F cleared
  function automatic logic [4:0] zn(input logic [WIDTH-1:0] r);
    return {3'b000, r == '0, r[WIDTH-1]};
  endfunction

  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;

  // Decode the incoming op: one-cycle result/flags/carry, or which iterative op to start
  always_comb begin
    sum      = '0;
    res_c    = '0;
    flg_c    = flags_q;
    cry_c    = carry_q;
    use_cin  = 1'b0;
    ovf      = 1'b0;
    is_shift = 1'b0;
    kind_c   = K_ONE;
    mode_c   = SH_LEFT;
    if (op == OP_R) begin
      case (exop)
        4'b0001: begin res_c = Rdest & Rsrc; flg_c = zn(res_c); end
        4'b0010: begin res_c = Rdest | Rsrc; flg_c = zn(res_c); end
        4'b0011: begin res_c = Rdest ^ Rsrc; flg_c = zn(res_c); end
        4'b0100: begin res_c = ~Rdest;       flg_c = zn(res_c); end
        4'b0101, 4'b0110, 4'b0111, 4'b1010: begin
          use_cin = (exop == 4'b0111) | (exop == 4'b1010);
          sum     = {1'b0, Rdest} + {1'b0, Rsrc} + {{WIDTH{1'b0}}, use_cin & carry_q};
          res_c   = sum[WIDTH-1:0];
          ovf     = ((exop == 4'b0101) | (exop == 4'b0111)) &
                    (Rdest[WIDTH-1] == Rsrc[WIDTH-1]) & (res_c[WIDTH-1] != Rdest[WIDTH-1]);
          cry_c   = sum[WIDTH];
          flg_c   = {sum[WIDTH], 1'b0, ovf, res_c == '0, res_c[WIDTH-1]};
        end
        4'b1001: begin
          sum   = {1'b0, Rdest} - {1'b0, Rsrc};
          res_c = sum[WIDTH-1:0];
          ovf   = (Rdest[WIDTH-1] != Rsrc[WIDTH-1]) & (res_c[WIDTH-1] != Rdest[WIDTH-1]);
          cry_c = sum[WIDTH];
          flg_c = {sum[WIDTH], 1'b0, ovf, res_c == '0, res_c[WIDTH-1]};
        end
        4'b1011, 4'b1000: begin
          flg_c = {1'b0, Rdest < Rsrc, 1'b0, Rdest == Rsrc, $signed(Rdest) < $signed(Rsrc)};
        end
`ifdef ALU_MUL_EN
        4'b1110: kind_c = K_MUL;
`endif
        default: ;
      endcase
    end else if (op == OP_SHIFT) begin
      case (exop)
        4'b0100, 4'b0110: begin is_shift = 1'b1; mode_c = SH_LEFT; end
        4'b0101:          begin is_shift = 1'b1; mode_c = SH_LRGT; end
        4'b0011:          begin is_shift = 1'b1; mode_c = SH_ARGT; end
        default: ;
      endcase
      if (is_shift) begin
        if (Rsrc[SHW-1:0] == '0) begin
          res_c = Rdest;
          flg_c = zn(Rdest);
        end else begin
          kind_c = K_SHIFT;
        end
      end
    end
  end

  // One-bit shift step for the iterating shifter
  always_comb begin
    case (sh_mode)
      SH_LEFT: sh_next = {sh_reg[WIDTH-2:0], 1'b0};
      SH_LRGT: sh_next = {1'b0, sh_reg[WIDTH-1:1]};
      default: sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-add step: accumulate the multiplicand when the current multiplier bit is set
  always_comb begin
    mul_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
  end
`endif

  // Control FSM with registered result, flags, carry and handshake state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      out_q       <= '0;
      flags_q     <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sh_reg      <= '0;
      sh_cnt      <= '0;
      sh_mode     <= SH_LEFT;
`ifdef ALU_MUL_EN
      mul_acc     <= '0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
`endif
    end else begin
      case (state)
        S_SHIFT: begin
          sh_reg <= sh_next;
          sh_cnt <= sh_cnt - CNT_ONE;
          if (sh_cnt == CNT_ONE) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            out_q       <= sh_next;
            flags_q     <= zn(sh_next);
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          mul_acc    <= mul_next;
          mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
          mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
          sh_cnt     <= sh_cnt - CNT_ONE;
          if (sh_cnt == CNT_ONE) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            out_q       <= mul_next[WIDTH-1:0];
            flags_q     <= {|mul_next[2*WIDTH-1:WIDTH], 2'b00,
                            mul_next[WIDTH-1:0] == '0, mul_next[WIDTH-1]};
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase

      // A new accept overrides the DONE->IDLE drain in the same cycle
      if (in_valid && in_ready) begin
        case (kind_c)
          K_SHIFT: begin
            state       <= S_SHIFT;
            out_valid_q <= 1'b0;
            sh_reg      <= Rdest;
            sh_cnt      <= {1'b0, Rsrc[SHW-1:0]};
            sh_mode     <= mode_c;
          end
`ifdef ALU_MUL_EN
          K_MUL: begin
            state       <= S_MUL;
            out_valid_q <= 1'b0;
            mul_acc     <= '0;
            mul_mcand   <= {{WIDTH{1'b0}}, Rdest};
            mul_mplier  <= Rsrc;
            sh_cnt      <= MUL_ITERS;
          end
`endif
          default: begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            out_q       <= res_c;
            flags_q     <= flg_c;
            carry_q     <= cry_c;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed results for alu_exec_unit
// (WIDTH=16). flags are {C,L,F,Z,N}. MUL vectors follow ALU_MUL_EN.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [3:0]  exop = 4'h0;
  logic [15:0] Rdest = 16'h0;
  logic [15:0] Rsrc = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] R = 4'b0000, SH = 4'b1000;
  localparam logic [3:0] NOP = 4'b0000, AND_ = 4'b0001, OR_ = 4'b0010, XOR_ = 4'b0011,
                         NOT_ = 4'b0100, ADD = 4'b0101, ADDU = 4'b0110, ADDC = 4'b0111,
                         ADDCU = 4'b1010, SUB = 4'b1001, CMP = 4'b1011, CMPU = 4'b1000;
  localparam logic [3:0] LSH = 4'b0100, RSH = 4'b0101, ALSH = 4'b0110, ARSH = 4'b0011;

  alu_exec_unit #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .exop(exop), .Rdest(Rdest), .Rsrc(Rsrc),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, wait for out_valid and check it all
  task automatic run_op(input string tag, input logic [3:0] o, input logic [3:0] e,
                        input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                        input logic [15:0] exp_out, input logic [4:0] exp_flags);
    int lat;
    @(negedge clk);
    op = o; exop = e; Rdest = a; Rsrc = b; in_valid = 1'b1;
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; Rdest = 16'hDEAD; Rsrc = 16'h0005; exop = 4'h0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    check({tag, ".flags"}, 32'(flags), 32'(exp_flags));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out", 32'(out), 32'd0);
    check("rst.flags", 32'(flags), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // arithmetic and carry chaining
    run_op("add_ovf",  R, ADD,   16'h7FFF, 16'h0001, 1, 16'h8000, 5'b00101);
    run_op("add_cy",   R, ADD,   16'hFFFF, 16'h0001, 1, 16'h0000, 5'b10010);
    run_op("addc1",    R, ADDC,  16'h0000, 16'h0000, 1, 16'h0001, 5'b00000);
    run_op("addc0",    R, ADDC,  16'h0000, 16'h0000, 1, 16'h0000, 5'b00010);
    run_op("sub_bor",  R, SUB,   16'h0001, 16'h0002, 1, 16'hFFFF, 5'b10001);
    run_op("addcu",    R, ADDCU, 16'h0001, 16'h0001, 1, 16'h0003, 5'b00000);
    run_op("addu_cy",  R, ADDU,  16'hFFFF, 16'h0002, 1, 16'h0001, 5'b10000);
    run_op("addu_nof", R, ADDU,  16'h7FFF, 16'h0001, 1, 16'h8000, 5'b00001);
    run_op("sub_ovf",  R, SUB,   16'h8000, 16'h0001, 1, 16'h7FFF, 5'b00100);

    // compares and logic keep the carry register
    run_op("add_cy2",  R, ADD,   16'hFFFF, 16'h0001, 1, 16'h0000, 5'b10010);
    run_op("cmp_neg",  R, CMP,   16'hFFFF, 16'h0001, 1, 16'h0000, 5'b00001);
    run_op("cmpu_neg", R, CMPU,  16'hFFFF, 16'h0001, 1, 16'h0000, 5'b00001);
    run_op("and",      R, AND_,  16'hF0F0, 16'h3C3C, 1, 16'h3030, 5'b00000);
    run_op("addc_kept",R, ADDC,  16'h0000, 16'h0000, 1, 16'h0001, 5'b00000);
    run_op("or",       R, OR_,   16'h00F0, 16'h0F00, 1, 16'h0FF0, 5'b00000);
    run_op("xor",      R, XOR_,  16'hFFFF, 16'h8001, 1, 16'h7FFE, 5'b00000);
    run_op("not",      R, NOT_,  16'h00FF, 16'h1234, 1, 16'hFF00, 5'b00001);
    run_op("cmp_eq",   R, CMP,   16'h0003, 16'h0003, 1, 16'h0000, 5'b00010);
    run_op("cmp_lt",   R, CMP,   16'h0001, 16'hFFFF, 1, 16'h0000, 5'b01000);
    run_op("nop",      R, NOP,   16'h1234, 16'h5678, 1, 16'h0000, 5'b01000);
    run_op("unk_op",   4'b0011, 4'b0001, 16'h1234, 16'h5678, 1, 16'h0000, 5'b01000);
    run_op("unk_sh",   SH, 4'b1111, 16'h1234, 16'h0003, 1, 16'h0000, 5'b01000);
`ifdef ALU_MUL_EN
    run_op("mul",      R, 4'b1110, 16'h0100, 16'h0100, 17, 16'h0000, 5'b10010);
    run_op("mul_small",R, 4'b1110, 16'h0012, 16'h0034, 17, 16'h03A8, 5'b00000);
`else
    run_op("mul_off",  R, 4'b1110, 16'h0100, 16'h0100, 1, 16'h0000, 5'b01000);
`endif

    // shifts
    run_op("arsh3",    SH, ARSH, 16'h8000, 16'h0003, 4,  16'hF000, 5'b00001);
    run_op("arsh_pos", SH, ARSH, 16'h4000, 16'h0002, 3,  16'h1000, 5'b00000);
    run_op("rsh15",    SH, RSH,  16'h8000, 16'h000F, 16, 16'h0001, 5'b00000);
    run_op("lsh15",    SH, LSH,  16'h0003, 16'h000F, 16, 16'h8000, 5'b00001);
    run_op("alsh4",    SH, ALSH, 16'h00FF, 16'h0004, 5,  16'h0FF0, 5'b00000);
    run_op("lsh0",     SH, LSH,  16'h0001, 16'h0000, 1,  16'h0001, 5'b00000);
    run_op("rsh_z",    SH, RSH,  16'h0001, 16'h0001, 2,  16'h0000, 5'b00010);
    run_op("lsh_hi",   SH, LSH,  16'h0001, 16'h0012, 3,  16'h0004, 5'b00000);

    // back-to-back single-cycle ops at full rate
    @(negedge clk);
    in_valid = 1'b1; op = R; exop = AND_; Rdest = 16'hFFFF; Rsrc = 16'h1234;
    @(posedge clk); #1;
    check("b2b0.valid", 32'(out_valid), 32'd1);
    check("b2b0.out", 32'(out), 32'h1234);
    exop = XOR_; Rdest = 16'h00FF; Rsrc = 16'h0F0F;
    @(posedge clk); #1;
    check("b2b1.valid", 32'(out_valid), 32'd1);
    check("b2b1.out", 32'(out), 32'h0FF0);
    exop = OR_; Rdest = 16'hA000; Rsrc = 16'h000A;
    @(posedge clk); #1;
    check("b2b2.out", 32'(out), 32'hA00A);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b.drain", 32'(out_valid), 32'd0);

    // backpressure: result held for 5 cycles while a pending op waits
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = R; exop = XOR_; Rdest = 16'hFFFF; Rsrc = 16'h8001;
    @(posedge clk); #1;
    exop = ADD; Rdest = 16'h0001; Rsrc = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      check("stall.valid", 32'(out_valid), 32'd1);
      check("stall.out", 32'(out), 32'h7FFE);
      check("stall.flags", 32'(flags), 32'd0);
      check("stall.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("stall.release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall.next_valid", 32'(out_valid), 32'd1);
    check("stall.next_out", 32'(out), 32'h0002);

    // reset in the middle of a long shift, with carry set beforehand
    run_op("pre_rst", R, ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 5'b10010);
    @(negedge clk);
    in_valid = 1'b1; op = SH; exop = LSH; Rdest = 16'h0001; Rsrc = 16'h000F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy.in_ready", 32'(in_ready), 32'd0);
    check("busy.valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.flags", 32'(flags), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.out", 32'(out), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("post_rst_addc", R, ADDC, 16'h0000, 16'h0000, 1, 16'h0000, 5'b00010);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
